icache_nway: RTL and testbench

- Parametrised N-way set-associative, read-only instruction cache between the CPU fetch stage and the line-wide physical memory port.
- Successor to the direct-mapped instruction cache. Adds configurable associativity, tree pseudo-LRU replacement and a whole-cache invalidate (flush) input.
- Blocking design: one outstanding request at a time. Hits return in 1 cycle after acceptance; misses fill one full line.

---
 rtl/icache_nway.sv | 239 +++++++++++++++++++++++
 tb/tb_icache_nway.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache, tree PLRU.
// Optional ICACHE_PERF_EN adds hit_count/miss_count outputs.
module icache_nway #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read,
  input  logic [31:0]                  mem_address,
  output logic                         mem_resp,
  output logic [31:0]                  mem_rdata,
  input  logic                         flush,
`ifdef ICACHE_PERF_EN
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
`endif
  output logic                         pmem_read,
  output logic [31:0]                  pmem_address,
  input  logic                         pmem_resp,
  input  logic [8*(2**S_OFFSET)-1:0]   pmem_rdata
);

  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int S_LINE   = 8 * (2**S_OFFSET);
  localparam int NUM_SETS = 2**S_INDEX;
  localparam int LEVELS   = $clog2(NUM_WAYS);
  localparam int W_BITS   = (NUM_WAYS > 1) ? LEVELS : 1;
  localparam int P_BITS   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } state_t;

  state_t              state_q;
  logic [31:2]         addr_q;
  logic                flush_pend_q;
  logic                mem_resp_q;
  logic [31:0]         mem_rdata_q;
  logic                pmem_read_q;
  logic [31:0]         pmem_addr_q;

  logic [S_TAG-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [S_LINE-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [P_BITS-1:0]   plru_q  [NUM_SETS];

  logic [S_INDEX-1:0]  set;
  logic [S_TAG-1:0]    tag;
  logic [S_OFFSET-3:0] wsel;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [W_BITS-1:0]   hit_way;
  logic [W_BITS-1:0]   victim;
  logic                inv_found;
  logic [31:0]         hit_word_d;
  logic [P_BITS-1:0]   plru_hit_d;
  logic [P_BITS-1:0]   plru_fill_d;
  logic                unused_addr;

  assign unused_addr = ^mem_address[1:0];

  assign set  = addr_q[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign tag  = addr_q[31 -: S_TAG];
  assign wsel = addr_q[S_OFFSET-1:2];

  // Walk the tree: each node bit selects the subtree holding the victim.
  function automatic logic [W_BITS-1:0] plru_victim(
    input logic [P_BITS-1:0] t
  );
    int n;
    logic [W_BITS-1:0] w;
    n = 0;
    w = '0;
    for (int l = 0; l < LEVELS; l++) begin
      w = W_BITS'(w << 1) | W_BITS'(t[n]);
      n = 2 * n + 1 + int'(t[n]);
    end
    return w;
  endfunction

  // Point every node on the path away from the way just used.
  function automatic logic [P_BITS-1:0] plru_touch(
    input logic [P_BITS-1:0] t,
    input logic [W_BITS-1:0] w
  );
    int n;
    logic d;
    logic [P_BITS-1:0] r;
    r = t;
    n = 0;
    for (int l = 0; l < LEVELS; l++) begin
      d = w[LEVELS-1-l];
      r[n] = ~d;
      n = 2 * n + 1 + int'(d);
    end
    return r;
  endfunction

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[set][w] && (tag_q[set][w] == tag);
      if (hit_vec[w]) hit_way = W_BITS'(w);
    end
  end

  assign hit = |hit_vec;

  // Victim: lowest invalid way, otherwise the PLRU choice.
  always_comb begin
    victim    = plru_victim(plru_q[set]);
    inv_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!inv_found && !valid_q[set][w]) begin
        victim    = W_BITS'(w);
        inv_found = 1'b1;
      end
    end
  end

  // Word and PLRU next-state for the current lookup/fill.
  always_comb begin
    hit_word_d  = data_q[set][hit_way][{wsel, 5'b0} +: 32];
    plru_hit_d  = plru_touch(plru_q[set], hit_way);
    plru_fill_d = plru_touch(plru_q[set], victim);
  end

  // Control FSM with valid/PLRU state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_resp_q   <= 1'b0;
      mem_rdata_q  <= '0;
      pmem_read_q  <= 1'b0;
      pmem_addr_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      mem_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush || flush_pend_q) begin
            flush_pend_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
              valid_q[s] <= '0;
              plru_q[s]  <= '0;
            end
          end else if (mem_read) begin
            addr_q  <= mem_address[31:2];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) flush_pend_q <= 1'b1;
          if (hit) begin
            mem_resp_q   <= 1'b1;
            mem_rdata_q  <= hit_word_d;
            plru_q[set]  <= plru_hit_d;
            state_q      <= IDLE;
          end else begin
            pmem_read_q  <= 1'b1;
            pmem_addr_q  <= {addr_q[31:S_OFFSET], {S_OFFSET{1'b0}}};
            state_q      <= MISS;
          end
        end
        MISS: begin
          if (flush) flush_pend_q <= 1'b1;
          if (pmem_resp) begin
            valid_q[set][victim] <= 1'b1;
            plru_q[set]          <= plru_fill_d;
            pmem_read_q          <= 1'b0;
            state_q              <= LOOKUP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data arrays: written only by a fill, never reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == MISS && pmem_resp) begin
      tag_q[set][victim]  <= tag;
      data_q[set][victim] <= pmem_rdata;
    end
  end

  // At most one way may match a given tag.
  a_onehot_hit: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == LOOKUP) |-> $onehot0(hit_vec)
  );

`ifdef ICACHE_PERF_EN
  logic        refill_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Hit/miss counters; the post-fill re-lookup is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == MISS && pmem_resp) begin
        refill_q <= 1'b1;
      end else if (state_q == LOOKUP) begin
        refill_q <= 1'b0;
      end
      if (state_q == LOOKUP && hit && !refill_q) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == LOOKUP && !hit) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = pmem_addr_q;

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: scoreboard bench for icache_nway (default parameters).
// Models line memory, fill latency, flush and reset scenarios.
module tb_icache_nway;

  localparam int LINE = 256;

  logic            clk;
  logic            rst;
  logic            mem_read;
  logic [31:0]     mem_address;
  logic            mem_resp;
  logic [31:0]     mem_rdata;
  logic            flush;
  logic            pmem_read;
  logic [31:0]     pmem_address;
  logic            pmem_resp;
  logic [LINE-1:0] pmem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0]     hit_count;
  logic [31:0]     miss_count;
`endif

  icache_nway dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .flush        (flush),
`ifdef ICACHE_PERF_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  int errors = 0;
  int checks = 0;
  int pm_lat = 3;
  bit pm_en  = 1;
  int pm_cnt = 0;
  int pm_fills = 0;
  int resp_cnt = 0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0044) return 32'hDEAD_BEEF;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [LINE-1:0] line_of(input logic [31:0] b);
    logic [LINE-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = word_of(b + 32'(4 * k));
    return l;
  endfunction

  // Line memory: answers a fill on the pm_lat-th cycle of pmem_read.
  always begin
    @(posedge clk); #1;
    if (pm_en) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (pmem_read) begin
        pm_cnt++;
        if (pm_cnt >= pm_lat) begin
          pmem_rdata = line_of(pmem_address);
          pmem_resp  = 1'b1;
          pm_cnt     = 0;
          pm_fills++;
        end
      end else begin
        pm_cnt = 0;
      end
    end else begin
      pm_cnt = 0;
    end
  end

  // Scoreboard: every response pops the oldest expected word.
  always begin
    logic [31:0] e;
    @(posedge clk); #1;
    if (mem_resp) begin
      resp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got=%h want=none", mem_rdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_rdata !== e) begin
          errors++;
          $display("FAIL rdata got=%h want=%h", mem_rdata, e);
        end
      end
    end
  end

  task automatic do_read(
    input  logic [31:0] a,
    input  int          exp_lat,
    input  int          exp_miss,
    input  bit          fl,
    output int          rd_cyc
  );
    int cyc;
    int f0;
    bit fdone;
    bit abad;
    logic [31:0] base;
    base = {a[31:5], 5'b0};
    exp_q.push_back(word_of(a));
    f0 = pm_fills;
    rd_cyc = 0;
    cyc = 0;
    fdone = 0;
    abad = 0;
    mem_address = a;
    mem_read = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (flush) begin
        flush = 1'b0;
      end else if (fl && !fdone && pmem_read) begin
        flush = 1'b1;
        fdone = 1;
      end
      if (pmem_read) begin
        rd_cyc++;
        if (pmem_address !== base) abad = 1;
      end
    end while (!mem_resp && cyc < 60);
    mem_read = 1'b0;
    flush = 1'b0;
    if (!mem_resp) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h got=no_resp want=resp", a);
      void'(exp_q.pop_back());
    end else begin
      if (exp_lat >= 0) begin
        checks++;
        if (cyc - 1 != exp_lat) begin
          errors++;
          $display("FAIL latency addr=%h got=%0d want=%0d",
                   a, cyc - 1, exp_lat);
        end
      end
      if (exp_miss >= 0) begin
        checks++;
        if (pm_fills - f0 != exp_miss) begin
          errors++;
          $display("FAIL fills addr=%h got=%0d want=%0d",
                   a, pm_fills - f0, exp_miss);
        end
      end
      if (rd_cyc > 0) begin
        checks++;
        if (abad) begin
          errors++;
          $display("FAIL pmem_addr addr=%h got=%h want=%h",
                   a, pmem_address, base);
        end
      end
    end
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_resp got=%b want=0", mem_resp);
    end
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_pmem_read got=%b want=0", pmem_read);
    end
    checks++;
    if (pmem_address !== 32'h0) begin
      errors++;
      $display("FAIL rst_pmem_addr got=%h want=0", pmem_address);
    end
    checks++;
    if (mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mem_rdata got=%h want=0", mem_rdata);
    end
  endtask

  task automatic test_cold_miss();
    int rc;
    do_read(32'h0000_0040, 5, 1, 0, rc);
    checks++;
    if (rc != 3) begin
      errors++;
      $display("FAIL pmem_read_held got=%0d want=3", rc);
    end
    do_read(32'h0000_0044, 1, 0, 0, rc);
  endtask

  task automatic test_assoc();
    int rc;
    flush_pulse();
    do_read(32'h0000_0040, 5, 1, 0, rc);
    do_read(32'h0000_0140, 5, 1, 0, rc);
    do_read(32'h0000_0240, 5, 1, 0, rc);
    do_read(32'h0000_0340, 5, 1, 0, rc);
    do_read(32'h0000_0040, 1, 0, 0, rc);
    do_read(32'h0000_0140, 1, 0, 0, rc);
    do_read(32'h0000_0240, 1, 0, 0, rc);
    do_read(32'h0000_0340, 1, 0, 0, rc);
`ifdef ICACHE_PERF_EN
    checks++;
    if (hit_count !== 32'd5) begin
      errors++;
      $display("FAIL hit_count got=%0d want=5", hit_count);
    end
    checks++;
    if (miss_count !== 32'd5) begin
      errors++;
      $display("FAIL miss_count got=%0d want=5", miss_count);
    end
`endif
  endtask

  task automatic test_plru();
    int rc;
    pm_lat = 2;
    do_read(32'h0000_0040, 1, 0, 0, rc);
    do_read(32'h0000_0240, 1, 0, 0, rc);
    do_read(32'h0000_0440, 4, 1, 0, rc);
    do_read(32'h0000_0040, 1, 0, 0, rc);
    do_read(32'h0000_0348, 1, 0, 0, rc);
    do_read(32'h0000_0140, 4, 1, 0, rc);
    pm_lat = 3;
  endtask

  task automatic test_back_to_back();
    int rc;
    do_read(32'h0000_0040, 1, 0, 0, rc);
    do_read(32'h0000_0044, 1, 0, 0, rc);
    do_read(32'h0000_005C, 1, 0, 0, rc);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_rdata !== word_of(32'h0000_005C)) begin
      errors++;
      $display("FAIL rdata_hold got=%h want=%h",
               mem_rdata, word_of(32'h0000_005C));
    end
  endtask

  task automatic test_stray_resp();
    int rc;
    pm_en = 0;
    pmem_rdata = '1;
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    pm_en = 1;
    do_read(32'h0000_0048, 1, 0, 0, rc);
  endtask

  task automatic test_flush();
    int rc;
    do_read(32'h0000_0080, 5, 1, 1, rc);
    do_read(32'h0000_0084, -1, 1, 0, rc);
  endtask

  task automatic test_reset_mid_fill();
    int n;
    int r0;
    int rc;
    pm_en = 0;
    mem_address = 32'h0000_00A0;
    mem_read = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pmem_read && n < 20);
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill_req got=%b want=1", pmem_read);
    end
    r0 = resp_cnt;
    mem_read = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop_pmem_read got=%b want=0", pmem_read);
    end
    @(posedge clk); #1;
    pmem_rdata = '1;
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_cnt != r0) begin
      errors++;
      $display("FAIL late_resp got=%0d want=%0d", resp_cnt, r0);
    end
    pm_en = 1;
    do_read(32'h0000_00A0, 5, 1, 0, rc);
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0;
    mem_address = '0;
    flush = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    test_reset();
    test_cold_miss();
    test_assoc();
    test_plru();
    test_back_to_back();
    test_stray_resp();
    test_flush();
    test_reset_mid_fill();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
